// File: rtl/ring_buffer_v2.sv
// rtl/ring_buffer_v2.sv - parametrised ring FIFO with level, threshold flags and synchronous flush
// Optional high-watermark output enabled by defining RB_PEAK_EN.
module ring_buffer_v2 #(
   parameter int WIDTH     = 32,
   parameter int DEPTH     = 16,
   parameter int AF_THRESH = DEPTH - 2,
   parameter int AE_THRESH = 2,
   parameter int LW        = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             i_valid,
   output logic             i_ready,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_valid,
   input  logic             o_ready,
   output logic [WIDTH-1:0] o_data,
   output logic [LW-1:0]    level,
   output logic             full,
   output logic             empty,
   output logic             almost_full,
   output logic             almost_empty,
   output logic [LW-1:0]    peak_level
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
   localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
   localparam logic [LW-1:0] AF_LVL   = LW'(AF_THRESH);
   localparam logic [LW-1:0] AE_LVL   = LW'(AE_THRESH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [LW-1:0]    level_q;
   logic [LW-1:0]    level_nxt;
   logic             wr;
   logic             rd;

   // Depth need not be a power of two, so the wrap is an explicit compare.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PW'(1);
   endfunction

   assign i_ready = (level_q != LVL_FULL);
   assign o_valid = (level_q != '0);
   assign wr      = i_valid & i_ready;
   assign rd      = o_valid & o_ready;

   always_comb begin
      level_nxt = level_q;
      if (flush)
         level_nxt = '0;
      else if (wr && !rd)
         level_nxt = level_q + LW'(1);
      else if (rd && !wr)
         level_nxt = level_q - LW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
      end else if (flush) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
      end else begin
         if (wr)
            wr_ptr <= ptr_inc(wr_ptr);
         if (rd)
            rd_ptr <= ptr_inc(rd_ptr);
         level_q <= level_nxt;
      end
   end

   // Storage carries no reset; only the bookkeeping above does.
   always_ff @(posedge clk) begin
      if (wr && !flush)
         mem[wr_ptr] <= i_data;
   end

   assign o_data       = mem[rd_ptr];
   assign level        = level_q;
   assign full         = (level_q == LVL_FULL);
   assign empty        = (level_q == '0);
   assign almost_full  = (level_q >= AF_LVL);
   assign almost_empty = (level_q <= AE_LVL);

`ifdef RB_PEAK_EN
   logic [LW-1:0] peak_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         peak_q <= '0;
      else if (flush)
         peak_q <= '0;
      else if (level_nxt > peak_q)
         peak_q <= level_nxt;
   end

   assign peak_level = peak_q;
`else
   assign peak_level = '0;
`endif

endmodule

// File: tb/tb_ring_buffer_v2.sv
// tb/tb_ring_buffer_v2.sv - randomized queue-model bench for ring_buffer_v2 (DEPTH 16 and DEPTH 5)
module tb_ring_buffer_v2;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic        a_flush, a_valid, a_ready, a_i_ready, a_o_valid;
   logic [31:0] a_data, a_o_data;
   logic [4:0]  a_level, a_peak;
   logic        a_full, a_empty, a_af, a_ae;

   logic        b_flush, b_valid, b_ready, b_i_ready, b_o_valid;
   logic [7:0]  b_data, b_o_data;
   logic [2:0]  b_level, b_peak;
   logic        b_full, b_empty, b_af, b_ae;

   ring_buffer_v2 u_a (
      .clk(clk), .rst_n(rst_n), .flush(a_flush),
      .i_valid(a_valid), .i_ready(a_i_ready), .i_data(a_data),
      .o_valid(a_o_valid), .o_ready(a_ready), .o_data(a_o_data),
      .level(a_level), .full(a_full), .empty(a_empty),
      .almost_full(a_af), .almost_empty(a_ae), .peak_level(a_peak)
   );

   ring_buffer_v2 #(.WIDTH(8), .DEPTH(5), .AF_THRESH(4), .AE_THRESH(1)) u_b (
      .clk(clk), .rst_n(rst_n), .flush(b_flush),
      .i_valid(b_valid), .i_ready(b_i_ready), .i_data(b_data),
      .o_valid(b_o_valid), .o_ready(b_ready), .o_data(b_o_data),
      .level(b_level), .full(b_full), .empty(b_empty),
      .almost_full(b_af), .almost_empty(b_ae), .peak_level(b_peak)
   );

   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] mq[$];
   logic [7:0]  qb[$];
   int          mpeak = 0;

   function automatic int exp_peak();
`ifdef RB_PEAK_EN
      return mpeak;
`else
      return 0;
`endif
   endfunction

   // One clock of instance A, with the queue model advanced on the same handshake rules.
   task automatic cyc_a(input logic v, input logic [31:0] d, input logic r, input logic f);
      bit wr, rd;
      a_valid = v; a_data = d; a_ready = r; a_flush = f;
      wr = v && (mq.size() < 16);
      rd = r && (mq.size() > 0);
      @(posedge clk); #1;
      if (f) begin
         mq.delete();
         mpeak = 0;
      end else begin
         if (rd) void'(mq.pop_front());
         if (wr) mq.push_back(d);
         if (mq.size() > mpeak) mpeak = mq.size();
      end
      a_valid = 1'b0; a_ready = 1'b0; a_flush = 1'b0;
   endtask

   task automatic test_reset();
      n_vec++; if (a_i_ready !== 1'b1) begin n_err++; $display("FAIL reset_i_ready got %b exp 1", a_i_ready); end
      n_vec++; if (a_o_valid !== 1'b0) begin n_err++; $display("FAIL reset_o_valid got %b exp 0", a_o_valid); end
      n_vec++; if (a_level !== 5'd0) begin n_err++; $display("FAIL reset_level got %0d exp 0", a_level); end
      n_vec++; if ({a_full, a_empty, a_af, a_ae} !== 4'b0101) begin n_err++; $display("FAIL reset_flags got %b exp 0101", {a_full, a_empty, a_af, a_ae}); end
      n_vec++; if (a_peak !== 5'd0) begin n_err++; $display("FAIL reset_peak got %0d exp 0", a_peak); end
      n_vec++; if ({b_level, b_empty, b_i_ready} !== 5'b00011) begin n_err++; $display("FAIL reset_b got %b exp 00011", {b_level, b_empty, b_i_ready}); end
   endtask

   task automatic test_fill_drain();
      for (int k = 1; k <= 16; k++) begin
         cyc_a(1'b1, $urandom, 1'b0, 1'b0);
         n_vec++; if (a_level !== 5'(k)) begin n_err++; $display("FAIL fill_level k=%0d got %0d exp %0d", k, a_level, k); end
         n_vec++; if ({a_af, a_full, a_i_ready, a_ae} !== {k >= 14, k == 16, k < 16, k <= 2}) begin
            n_err++; $display("FAIL fill_flags k=%0d got %b exp %b", k, {a_af, a_full, a_i_ready, a_ae}, {k >= 14, k == 16, k < 16, k <= 2});
         end
      end
      cyc_a(1'b1, 32'hdead_beef, 1'b0, 1'b0);
      n_vec++; if (a_level !== 5'd16) begin n_err++; $display("FAIL overfill_level got %0d exp 16", a_level); end
      for (int k = 0; k < 16; k++) begin
         n_vec++; if (a_o_valid !== 1'b1 || a_o_data !== mq[0]) begin
            n_err++; $display("FAIL drain_data k=%0d got %b/%h exp 1/%h", k, a_o_valid, a_o_data, mq[0]);
         end
         cyc_a(1'b0, '0, 1'b1, 1'b0);
      end
      n_vec++; if (a_empty !== 1'b1 || a_o_valid !== 1'b0) begin n_err++; $display("FAIL drain_empty got %b/%b exp 1/0", a_empty, a_o_valid); end
   endtask

   task automatic test_back_to_back();
      cyc_a(1'b0, '0, 1'b0, 1'b1);
      for (int k = 0; k < 3; k++) cyc_a(1'b1, $urandom, 1'b0, 1'b0);
      for (int k = 0; k < 10; k++) begin
         n_vec++; if (a_o_data !== mq[0]) begin n_err++; $display("FAIL b2b_data k=%0d got %h exp %h", k, a_o_data, mq[0]); end
         cyc_a(1'b1, $urandom, 1'b1, 1'b0);
         n_vec++; if (a_level !== 5'd3) begin n_err++; $display("FAIL b2b_level k=%0d got %0d exp 3", k, a_level); end
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         n_vec++; if (a_level !== 5'(mq.size()) || a_full !== (mq.size() == 16) || a_empty !== (mq.size() == 0) ||
                      a_af !== (mq.size() >= 14) || a_ae !== (mq.size() <= 2) || a_i_ready !== (mq.size() < 16) ||
                      a_o_valid !== (mq.size() > 0)) begin
            n_err++; $display("FAIL rand_state k=%0d level got %0d exp %0d flags %b%b%b%b%b%b", k, a_level, mq.size(),
                              a_full, a_empty, a_af, a_ae, a_i_ready, a_o_valid);
         end
         if (mq.size() > 0) begin
            n_vec++; if (a_o_data !== mq[0]) begin n_err++; $display("FAIL rand_data k=%0d got %h exp %h", k, a_o_data, mq[0]); end
         end
         n_vec++; if (a_peak !== 5'(exp_peak())) begin n_err++; $display("FAIL rand_peak k=%0d got %0d exp %0d", k, a_peak, exp_peak()); end
         cyc_a(($urandom % 8) < 5, $urandom, ($urandom % 8) < 4, ($urandom % 64) == 0);
      end
   endtask

   task automatic test_flush();
      logic [31:0] x;
      cyc_a(1'b0, '0, 1'b0, 1'b1);
      for (int k = 0; k < 9; k++) cyc_a(1'b1, $urandom, 1'b0, 1'b0);
      n_vec++; if (a_level !== 5'd9) begin n_err++; $display("FAIL flush_pre_level got %0d exp 9", a_level); end
      cyc_a(1'b1, $urandom, 1'b1, 1'b1);
      n_vec++; if ({a_level, a_empty, a_o_valid} !== {5'd0, 1'b1, 1'b0}) begin
         n_err++; $display("FAIL flush_state got %0d/%b/%b exp 0/1/0", a_level, a_empty, a_o_valid);
      end
      x = $urandom;
      cyc_a(1'b1, x, 1'b0, 1'b0);
      n_vec++; if (a_o_valid !== 1'b1 || a_o_data !== x) begin n_err++; $display("FAIL flush_next got %b/%h exp 1/%h", a_o_valid, a_o_data, x); end
   endtask

   task automatic test_peak();
      cyc_a(1'b0, '0, 1'b0, 1'b1);
      for (int k = 0; k < 11; k++) cyc_a(1'b1, $urandom, 1'b0, 1'b0);
      for (int k = 0; k < 11; k++) cyc_a(1'b0, '0, 1'b1, 1'b0);
      n_vec++; if (a_level !== 5'd0 || a_peak !== 5'(exp_peak())) begin
         n_err++; $display("FAIL peak_hold got %0d/%0d exp 0/%0d", a_level, a_peak, exp_peak());
      end
      cyc_a(1'b0, '0, 1'b0, 1'b1);
      n_vec++; if (a_peak !== 5'd0) begin n_err++; $display("FAIL peak_flush got %0d exp 0", a_peak); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] va, vb;
      cyc_a(1'b0, '0, 1'b0, 1'b1);
      for (int k = 0; k < 7; k++) cyc_a(1'b1, $urandom, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      n_vec++; if ({a_level, a_empty, a_o_valid, a_i_ready, a_full, a_af, a_ae} !== {5'd0, 6'b101001} || a_peak !== 5'd0) begin
         n_err++; $display("FAIL async_reset got %0d/%b%b%b%b%b%b peak %0d exp 0/101001 peak 0", a_level, a_empty, a_o_valid,
                           a_i_ready, a_full, a_af, a_ae, a_peak);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      mq.delete(); qb.delete(); mpeak = 0;
      va = $urandom; vb = $urandom;
      cyc_a(1'b1, va, 1'b0, 1'b0);
      cyc_a(1'b1, vb, 1'b0, 1'b0);
      n_vec++; if (a_o_data !== va) begin n_err++; $display("FAIL post_reset_a got %h exp %h", a_o_data, va); end
      cyc_a(1'b0, '0, 1'b1, 1'b0);
      n_vec++; if (a_o_data !== vb || a_level !== 5'd1) begin n_err++; $display("FAIL post_reset_b got %h/%0d exp %h/1", a_o_data, a_level, vb); end
   endtask

   task automatic test_wrap_b();
      int  nw = 0, nr = 0, cyc = 0;
      bit  v, r, wr, rd;
      logic [7:0] d;
      while ((nw < 23 || qb.size() > 0) && cyc < 400) begin
         cyc++;
         n_vec++; if (b_level !== 3'(qb.size()) || b_full !== (qb.size() == 5) || b_af !== (qb.size() >= 4) || b_ae !== (qb.size() <= 1)) begin
            n_err++; $display("FAIL wrap_state c=%0d got %0d/%b%b%b exp %0d", cyc, b_level, b_full, b_af, b_ae, qb.size());
         end
         if (qb.size() > 0) begin
            n_vec++; if (b_o_data !== qb[0]) begin n_err++; $display("FAIL wrap_data c=%0d got %h exp %h", cyc, b_o_data, qb[0]); end
         end
         v = (nw < 23) && ($urandom % 4 != 0);
         r = (qb.size() >= 3) || ($urandom % 2 == 0);
         d = 8'($urandom);
         b_valid = v; b_data = d; b_ready = r;
         wr = v && (qb.size() < 5);
         rd = r && (qb.size() > 0);
         @(posedge clk); #1;
         if (rd) begin void'(qb.pop_front()); nr++; end
         if (wr) begin qb.push_back(d); nw++; end
         b_valid = 1'b0; b_ready = 1'b0;
      end
      n_vec++; if (nr !== 23 || b_empty !== 1'b1) begin n_err++; $display("FAIL wrap_done got reads %0d empty %b exp 23/1", nr, b_empty); end
   endtask

   initial begin
      rst_n = 1'b0;
      a_flush = 0; a_valid = 0; a_ready = 0; a_data = '0;
      b_flush = 0; b_valid = 0; b_ready = 0; b_data = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      test_reset();
      test_fill_drain();
      test_back_to_back();
      test_random();
      test_flush();
      test_peak();
      test_wrap_b();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
